// File: rtl/fifo_trans_recorder_if.sv
// Trace-record stream of fifo_trans_recorder: one packed record per valid/ready beat.
interface fifo_trans_recorder_if #(
    parameter int unsigned REC_W = 34
);
    logic             rec_valid_o;
    logic             rec_ready_i;
    logic [REC_W-1:0] rec_data_o;

    modport master (output rec_valid_o, output rec_data_o, input rec_ready_i);
    modport slave  (input rec_valid_o, input rec_data_o, output rec_ready_i);
endinterface

// File: rtl/fifo_trans_recorder.sv
// Passive valid/yumi FIFO port recorder: timestamped trace records, occupancy model, error flags.
// Optional data scoreboard enabled by defining FIFO_TRANS_SCOREBOARD_EN.
module fifo_trans_recorder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned TS_W        = 16,
    localparam int unsigned REC_W      = TS_W + 2 + 2 * WIDTH,
    localparam int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dut_reset_i,
    input  logic                  valid_i,
    input  logic                  yumi_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic [WIDTH-1:0]      data_o_i,
    fifo_trans_recorder_if.master rec_if,
    output logic [OCC_W-1:0]      occupancy_o,
    output logic                  err_underflow_o,
    output logic                  err_overflow_o,
    output logic                  err_data_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int unsigned TP_W     = $clog2(TRACE_DEPTH);
    localparam logic [1:0]  OP_RESET = 2'b00;

    logic [TS_W-1:0]  r_ts;
    logic             r_dut_rst;
    logic [REC_W-1:0] r_mem [TRACE_DEPTH];
    logic [TP_W:0]    r_wr_ptr;
    logic [TP_W:0]    r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_err_unf;
    logic             r_err_ovf;
    logic [7:0]       r_drop;

    logic [TS_W-1:0]  w_ts_next;
    logic             w_enq;
    logic             w_deq;
    logic             w_rst_edge;
    logic             w_rec_new;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_enq_word;
    logic [WIDTH-1:0] w_deq_word;
    logic [REC_W-1:0] w_rec;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_unf_set;
    logic             w_ovf_set;

    // A record carries the timestamp value the counter takes on its sampling edge.
    assign w_ts_next  = r_ts + 1'b1;
    assign w_enq      = valid_i & ~dut_reset_i;
    assign w_deq      = yumi_i & ~dut_reset_i;
    assign w_rst_edge = dut_reset_i & ~r_dut_rst;
    assign w_rec_new  = w_rst_edge | w_enq | w_deq;
    assign w_op       = dut_reset_i ? OP_RESET : {w_enq, w_deq};
    assign w_enq_word = w_enq ? data_i : '0;
    assign w_deq_word = w_deq ? data_o_i : '0;
    assign w_rec      = {w_ts_next, w_op, w_enq_word, w_deq_word};

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[TP_W] != r_rd_ptr[TP_W]) &&
                     (r_wr_ptr[TP_W-1:0] == r_rd_ptr[TP_W-1:0]);
    assign w_pop   = ~w_empty & rec_if.rec_ready_i;
    assign w_push  = w_rec_new & (~w_full | w_pop);
    assign w_drop  = w_rec_new & w_full & ~w_pop;

    always_comb begin
        w_occ_next = r_occ;
        w_unf_set  = 1'b0;
        w_ovf_set  = 1'b0;
        if (dut_reset_i) begin
            w_occ_next = '0;
        end else if (w_enq && !w_deq) begin
            if (r_occ == OCC_W'(DEPTH)) begin
                w_ovf_set = 1'b1;
            end else begin
                w_occ_next = r_occ + 1'b1;
            end
        end else if (w_deq) begin
            // BOTH at zero is an underflow and leaves the model empty.
            if (r_occ == '0) begin
                w_unf_set = 1'b1;
            end else if (!w_enq) begin
                w_occ_next = r_occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts      <= '0;
            r_dut_rst <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_err_unf <= 1'b0;
            r_err_ovf <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_ts      <= w_ts_next;
            r_dut_rst <= dut_reset_i;
            r_occ     <= w_occ_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_unf_set) r_err_unf <= 1'b1;
            if (w_ovf_set) r_err_ovf <= 1'b1;
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr[TP_W-1:0]] <= w_rec;
        end
    end

    assign rec_if.rec_valid_o = ~w_empty;
    assign rec_if.rec_data_o  = r_mem[r_rd_ptr[TP_W-1:0]];
    assign occupancy_o        = r_occ;
    assign err_underflow_o    = r_err_unf;
    assign err_overflow_o     = r_err_ovf;
    assign drop_cnt_o         = r_drop;

`ifdef FIFO_TRANS_SCOREBOARD_EN
    localparam int unsigned SP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_shadow [DEPTH];
    logic [SP_W-1:0]  r_sh_head;
    logic [SP_W-1:0]  r_sh_tail;
    logic             r_err_data;
    logic             w_sh_push;
    logic             w_sh_pop;
    logic             w_cmp;
    logic [WIDTH-1:0] w_cmp_ref;

    function automatic logic [SP_W-1:0] sh_inc(input logic [SP_W-1:0] p);
        return (p == SP_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An empty-model BOTH is a pass-through, so the dequeued word must equal data_i.
    always_comb begin
        w_sh_push = w_enq && (w_deq ? (r_occ != '0) : (r_occ != OCC_W'(DEPTH)));
        w_sh_pop  = w_deq && (r_occ != '0);
        w_cmp     = w_deq && ((r_occ != '0) || w_enq);
        w_cmp_ref = (r_occ == '0) ? data_i : r_shadow[r_sh_head];
    end

    always_ff @(posedge clk) begin
        if (reset || dut_reset_i) begin
            r_sh_head <= '0;
            r_sh_tail <= '0;
        end else begin
            if (w_sh_pop) r_sh_head <= sh_inc(r_sh_head);
            if (w_sh_push) r_sh_tail <= sh_inc(r_sh_tail);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_data <= 1'b0;
        end else if (w_cmp && (data_o_i != w_cmp_ref)) begin
            r_err_data <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_sh_push) begin
            r_shadow[r_sh_tail] <= data_i;
        end
    end

    assign err_data_o = r_err_data;
`else
    assign err_data_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_trans_recorder.sv
// Scoreboard bench for fifo_trans_recorder: expected records queued at drive time, popped on output.
module tb_fifo_trans_recorder;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned DEPTH       = 16;
    localparam int unsigned TRACE_DEPTH = 8;
    localparam int unsigned TS_W        = 16;
    localparam int unsigned REC_W       = TS_W + 2 + 2 * WIDTH;
    localparam int unsigned OCC_W       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             dut_reset_i;
    logic             valid_i;
    logic             yumi_i;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o_i;
    logic [OCC_W-1:0] occupancy_o;
    logic             err_underflow_o;
    logic             err_overflow_o;
    logic             err_data_o;
    logic [7:0]       drop_cnt_o;

    fifo_trans_recorder_if #(.REC_W(REC_W)) rec_if ();

    always #5 clk = ~clk;

    fifo_trans_recorder #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .TRACE_DEPTH(TRACE_DEPTH),
        .TS_W       (TS_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dut_reset_i    (dut_reset_i),
        .valid_i        (valid_i),
        .yumi_i         (yumi_i),
        .data_i         (data_i),
        .data_o_i       (data_o_i),
        .rec_if         (rec_if),
        .occupancy_o    (occupancy_o),
        .err_underflow_o(err_underflow_o),
        .err_overflow_o (err_overflow_o),
        .err_data_o     (err_data_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [REC_W-1:0] exp_q[$];
    logic [WIDTH-1:0] m_shadow[$];
    int               m_ts;
    int               m_occ;
    int               m_drop;
    bit               m_unf;
    bit               m_ovf;
    bit               m_derr;
    bit               m_prev_drst;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic sb_cmp(input logic [WIDTH-1:0] ref_w, input logic [WIDTH-1:0] got_w);
`ifdef FIFO_TRANS_SCOREBOARD_EN
        if (ref_w != got_w) m_derr = 1'b1;
`else
        if (ref_w != got_w) m_derr = m_derr;
`endif
    endtask

    task automatic check_status();
        check_eq("occupancy", occupancy_o, m_occ);
        check_eq("err_underflow", err_underflow_o, m_unf);
        check_eq("err_overflow", err_overflow_o, m_ovf);
        check_eq("err_data", err_data_o, m_derr);
        check_eq("drop_cnt", drop_cnt_o, m_drop);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dut_reset_i = 1'b0;
        valid_i = 1'b0;
        yumi_i = 1'b0;
        data_i = '0;
        data_o_i = '0;
        rec_if.rec_ready_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_shadow.delete();
        m_ts = 0;
        m_occ = 0;
        m_drop = 0;
        m_unf = 1'b0;
        m_ovf = 1'b0;
        m_derr = 1'b0;
        m_prev_drst = 1'b0;
        check_eq("rst_rec_valid", rec_if.rec_valid_o, 1'b0);
        check_status();
    endtask

    // One observed cycle: drive, check the record head, update the model, clock, check status.
    task automatic step(input bit drst, input bit v, input bit y, input logic [WIDTH-1:0] din,
                        input logic [WIDTH-1:0] dout, input bit rdy);
        bit               enq;
        bit               deq;
        bit               rec;
        logic [1:0]       op;
        logic [WIDTH-1:0] ew;
        logic [WIDTH-1:0] dw;
        logic [REC_W-1:0] r;
        dut_reset_i = drst;
        valid_i = v;
        yumi_i = y;
        data_i = din;
        data_o_i = dout;
        rec_if.rec_ready_i = rdy;
        @(negedge clk);
        check_eq("rec_valid", rec_if.rec_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("rec_data", rec_if.rec_data_o, exp_q[0]);
            if (rdy) void'(exp_q.pop_front());
        end
        enq = v && !drst;
        deq = y && !drst;
        rec = (drst && !m_prev_drst) || enq || deq;
        op = drst ? 2'b00 : {enq, deq};
        ew = enq ? din : '0;
        dw = deq ? dout : '0;
        r = {TS_W'(m_ts + 1), op, ew, dw};
        if (rec) begin
            if (exp_q.size() < TRACE_DEPTH) exp_q.push_back(r);
            else if (m_drop < 255) m_drop++;
        end
        if (drst) begin
            m_occ = 0;
            m_shadow.delete();
        end else if (enq && !deq) begin
            if (m_occ == DEPTH) m_ovf = 1'b1;
            else begin
                m_occ++;
                m_shadow.push_back(din);
            end
        end else if (deq && !enq) begin
            if (m_occ == 0) m_unf = 1'b1;
            else begin
                m_occ--;
                sb_cmp(m_shadow.pop_front(), dout);
            end
        end else if (enq && deq) begin
            if (m_occ == 0) begin
                m_unf = 1'b1;
                sb_cmp(din, dout);
            end else begin
                sb_cmp(m_shadow.pop_front(), dout);
                m_shadow.push_back(din);
            end
        end
        m_prev_drst = drst;
        @(posedge clk);
        #1;
        m_ts = (m_ts + 1) % (1 << TS_W);
        check_status();
    endtask

    initial begin
        do_reset();

        // ENQ 5,6,7 -> ts 1,2,3
        step(0, 1, 0, 8'h05, 8'h00, 1);
        step(0, 1, 0, 8'h06, 8'h00, 1);
        step(0, 1, 0, 8'h07, 8'h00, 1);
        check_eq("occ_after_3", occupancy_o, 3);
        step(0, 0, 0, 8'h00, 8'h00, 1);

        // Backpressure: 9 records into an 8-entry buffer
        for (int i = 0; i < 9; i++) step(0, 1, 0, 8'(8'h10 + i), 8'h00, 0);
        check_eq("drop_after_9", drop_cnt_o, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 8'h00, 8'h00, 1);

        // Underflow is sticky
        do_reset();
        step(0, 0, 1, 8'h00, 8'h3C, 1);
        check_eq("unf_set", err_underflow_o, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 8'h00, 1);
        check_eq("unf_sticky", err_underflow_o, 1'b1);

        // Full model: BOTH keeps occupancy, extra ENQ overflows
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i), 8'h00, 1);
        step(0, 1, 1, 8'h99, 8'h00, 1);
        check_eq("occ_full_both", occupancy_o, 16);
        check_eq("no_ovf_both", err_overflow_o, 1'b0);
        step(0, 1, 0, 8'h55, 8'h00, 1);
        check_eq("ovf_set", err_overflow_o, 1'b1);

        // Observed reset held 3 cycles: one RESET record, strobes ignored
        for (int i = 0; i < 3; i++) step(1, 1, 1, 8'hEE, 8'hDD, 1);
        check_eq("occ_after_dut_rst", occupancy_o, 0);
        check_eq("ovf_kept", err_overflow_o, 1'b1);
        step(0, 0, 0, 8'h00, 8'h00, 1);
        step(0, 0, 0, 8'h00, 8'h00, 1);

`ifdef FIFO_TRANS_SCOREBOARD_EN
        do_reset();
        step(0, 1, 0, 8'hA1, 8'h00, 1);
        step(0, 1, 0, 8'hB2, 8'h00, 1);
        step(0, 0, 1, 8'h00, 8'hA1, 1);
        check_eq("derr_first_deq", err_data_o, 1'b0);
        step(0, 0, 1, 8'h00, 8'hC3, 1);
        check_eq("derr_second_deq", err_data_o, 1'b1);
`endif

        // Random traffic with occasional observed resets and backpressure
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
                 8'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 8'h00, 1);
        check_eq("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
